// File: rtl/aes_ser_pkg.sv
// Shared types and constants for the AES output-path serializer sequencer.
//   state_e     : controller FSM states (idle, draining the serializer, last-byte flush)
//   N_BYTES     : bytes per AES block; also the depth of the 16-to-1 serializer
//   CNT_W       : width of the read-request counter; must be able to hold N_BYTES
//   byte_idx_t  : index of a byte within a block
package aes_ser_pkg;

  localparam int unsigned N_BYTES = 16;
  localparam int unsigned CNT_W   = 5;

  typedef logic [3:0] byte_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush
  } state_e;

  // True when the request about to be issued reads the final byte of the block.
  function automatic logic is_last_req(logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(N_BYTES - 1);
  endfunction

endpackage

// File: rtl/aes_ser_drain_ctrl.sv
// Sequencer for the 16-to-1 byte serializer on the AES-256 output path.
// Takes a finished block from the core via valid/ready, pulses the serializer load, then
// issues one read request per byte, paced by output-FIFO backpressure. The FIFO write strobe
// is delayed one cycle to line up with the serializer's registered byte output. The 128-bit
// data bus runs core -> serializer directly; this block only sequences.
//
// Ports:
//   clk        clock
//   resetn     synchronous reset, active-high (shared with the serializer)
//   blk_valid  core presents a block on the serializer input bus
//   blk_ready  controller accepts the block this cycle (combinational)
//   ser_wr_en  serializer load strobe (combinational)
//   ser_req    serializer read request (combinational)
//   ser_empty  serializer reports no bytes left
//   fifo_afull output FIFO has at most one free slot
//   fifo_wr_en write the serializer byte output into the FIFO (registered)
//   byte_idx   index of the byte being written (registered)
//   blk_done   one-cycle pulse with the last byte write (registered)
//   busy       controller is not idle (combinational)
//   err        sticky sequencing error, cleared only by reset (registered)
module aes_ser_drain_ctrl
  import aes_ser_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic       ser_wr_en,
  output logic       ser_req,
  input  logic       ser_empty,
  input  logic       fifo_afull,
  output logic       fifo_wr_en,
  output logic [3:0] byte_idx,
  output logic       blk_done,
  output logic       busy,
  output logic       err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic             fifo_wr_en_q, fifo_wr_en_d;
  byte_idx_t        byte_idx_q, byte_idx_d;
  logic             blk_done_q, blk_done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d      = state_q;
    req_cnt_d    = req_cnt_q;
    fifo_wr_en_d = 1'b0;
    byte_idx_d   = byte_idx_q;
    blk_done_d   = 1'b0;
    err_d        = err_q;
    blk_ready    = 1'b0;
    ser_wr_en    = 1'b0;
    ser_req      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A serializer still holding bytes, or a latched error, blocks new blocks.
        blk_ready = ser_empty & ~err_q;
        ser_wr_en = blk_valid & blk_ready;
        if (ser_wr_en) begin
          req_cnt_d = '0;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (ser_empty) begin
          // Serializer ran dry before all bytes were requested: abort, no further reads.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          // afull threshold leaves room for the write still in flight from the last request.
          ser_req = ~fifo_afull;
          if (ser_req) begin
            req_cnt_d    = req_cnt_q + 1'b1;
            fifo_wr_en_d = 1'b1;
            byte_idx_d   = byte_idx_t'(req_cnt_q);
            if (is_last_req(req_cnt_q)) begin
              blk_done_d = 1'b1;
              state_d    = StFlush;
            end
          end
        end
      end
      StFlush: begin
        // Last byte is written this cycle; the serializer must now be empty.
        if (!ser_empty) begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= StIdle;
      req_cnt_q    <= '0;
      fifo_wr_en_q <= 1'b0;
      byte_idx_q   <= '0;
      blk_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_cnt_q    <= req_cnt_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      byte_idx_q   <= byte_idx_d;
      blk_done_q   <= blk_done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign fifo_wr_en = fifo_wr_en_q;
  assign byte_idx   = byte_idx_q;
  assign blk_done   = blk_done_q;
  assign err        = err_q;

endmodule
